mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response and memory-bus signals of the memory access unit.
// The slave modport is the unit's own view; the master modport drives it.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_W-1:0]     rdata;
  logic                  cpu_stb_o;
  logic                  mem_w;
  logic [ADDR_W-1:0]     Addr_out;
  logic [DATA_W-1:0]     data_out;
  logic [DATA_W/8-1:0]   sel_o;
  logic [DATA_W-1:0]     data_in;
  logic                  MIO_ready;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, data_in, MIO_ready,
    output busy, done, err, rdata, cpu_stb_o, mem_w, Addr_out, data_out, sel_o
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, data_in, MIO_ready,
    input  busy, done, err, rdata, cpu_stb_o, mem_w, Addr_out, data_out, sel_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-access load/store sequencer: aligns CPU requests onto byte lanes of the
// memory bus, waits for MIO_ready with a timeout, and extends load results.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);
  localparam int SEL_W  = DATA_W / 8;
  localparam int LANE_W = $clog2(SEL_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;

  state_t              state_q, state_d;
  logic                stb_q, stb_d;
  logic                memw_q, memw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                errp_q, errp_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                sx_q, sx_d;
  logic [CNT_W-1:0]    wait_q, wait_d;

  function automatic logic [SEL_W-1:0] lane_sel(input logic [1:0] sz, input logic [LANE_W-1:0] lane);
    case (sz)
      2'b00:   return SEL_W'(1) << lane;
      2'b01:   return SEL_W'(3) << lane;
      2'b10:   return SEL_W'(15) << lane;
      default: return '1;
    endcase
  endfunction

  // Misaligned offset or a dword on a 32-bit bus.
  function automatic logic req_bad(input logic [1:0] sz, input logic [LANE_W-1:0] lane);
    logic [2:0] low;
    low = 3'(lane);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return low[0];
      2'b10:   return |low[1:0];
      default: return (DATA_W != 64) || (|low);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                   input logic [1:0] sz, input logic sx);
    int unsigned              drop;
    logic        [DATA_W-1:0] up_u;
    logic signed [DATA_W-1:0] up_s;
    case (sz)
      2'b00:   drop = DATA_W - 8;
      2'b01:   drop = DATA_W - 16;
      2'b10:   drop = DATA_W - 32;
      default: drop = 0;
    endcase
    up_u = raw << drop;
    up_s = $signed(up_u);
    if (sx) return DATA_W'(up_s >>> drop);
    return up_u >> drop;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      memw_q  <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      errp_q  <= 1'b0;
      lane_q  <= '0;
      size_q  <= '0;
      sx_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      memw_q  <= memw_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      errp_q  <= errp_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      sx_q    <= sx_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    memw_d  = memw_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    errp_d  = errp_q;
    lane_d  = lane_q;
    size_d  = size_q;
    sx_d    = sx_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        // done_q gates acceptance so a new request starts the cycle after done.
        if (bus.req && !done_q) begin
          lane_d = bus.addr[LANE_W-1:0];
          size_d = bus.size;
          sx_d   = bus.sign_ext;
          if (req_bad(bus.size, bus.addr[LANE_W-1:0])) begin
            errp_d  = 1'b1;
            state_d = FINISH;
          end else begin
            errp_d  = 1'b0;
            state_d = ACCESS;
            stb_d   = 1'b1;
            memw_d  = bus.we;
            addr_d  = {bus.addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            dout_d  = bus.wdata << {bus.addr[LANE_W-1:0], 3'b000};
            sel_d   = lane_sel(bus.size, bus.addr[LANE_W-1:0]);
            wait_d  = '0;
          end
        end
      end
      ACCESS: begin
        // Ready wins over a coincident timeout.
        if (bus.MIO_ready) begin
          stb_d   = 1'b0;
          memw_d  = 1'b0;
          errp_d  = 1'b0;
          state_d = FINISH;
          if (!memw_q) rdata_d = extend_load(bus.data_in >> {lane_q, 3'b000}, size_q, sx_q);
        end else if (wait_q == WAIT_LAST) begin
          stb_d   = 1'b0;
          memw_d  = 1'b0;
          errp_d  = 1'b1;
          state_d = FINISH;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        err_d   = errp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || done_d;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.cpu_stb_o = stb_q;
  assign bus.mem_w     = memw_q;
  assign bus.Addr_out  = addr_q;
  assign bus.data_out  = dout_q;
  assign bus.sel_o     = sel_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance (default TIMEOUT) share clock and reset.
module tb_mem_access_unit;
  logic clk;
  logic reset;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .reset(reset), .bus(b32)
  );
  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) u64 (
    .clk(clk), .reset(reset), .bus(b64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          d64;
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [63:0] wd;
    logic [63:0] di;
    int          waits;
  } stim_t;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    logic        keep;
    logic [7:0]  sel;
    logic [31:0] addr;
    logic [63:0] dout;
    logic        memw;
    int          stb_n;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          passed;
  int          total;
  logic [63:0] last32;
  logic [63:0] last64;

  logic [7:0]  o_sel;
  logic [31:0] o_addr;
  logic [63:0] o_dout;
  logic [63:0] o_rdata;
  logic        o_memw, o_err, o_busy_ok, o_stable, o_done_once;
  int          o_stb_n, o_done_cyc;

  // Issue one request and observe the bus/response until done (bounded).
  task automatic run_access(input stim_t s);
    logic        s_stb, s_busy, s_done, s_err, s_memw;
    logic [7:0]  s_sel;
    logic [31:0] s_addr;
    logic [63:0] s_dout, s_rdata;
    bit          got;
    o_stb_n = 0; o_done_cyc = -1; o_stable = 1'b1; o_busy_ok = 1'b1; o_done_once = 1'b0;
    o_sel = '0; o_addr = '0; o_dout = '0; o_memw = 1'b0; o_err = 1'b0; o_rdata = '0;
    if (s.d64) begin
      b64.req = 1'b1; b64.we = s.w; b64.size = s.sz; b64.sign_ext = s.sx;
      b64.addr = s.a; b64.wdata = s.wd; b64.data_in = s.di;
    end else begin
      b32.req = 1'b1; b32.we = s.w; b32.size = s.sz; b32.sign_ext = s.sx;
      b32.addr = s.a; b32.wdata = s.wd[31:0]; b32.data_in = s.di[31:0];
    end
    @(posedge clk); #1;
    b32.req = 1'b0;
    b64.req = 1'b0;
    got = 1'b0;
    for (int cyc = 1; cyc <= 24 && !got; cyc++) begin
      if (s.d64) begin
        s_stb = b64.cpu_stb_o; s_busy = b64.busy; s_done = b64.done; s_err = b64.err;
        s_memw = b64.mem_w; s_sel = b64.sel_o; s_addr = b64.Addr_out;
        s_dout = b64.data_out; s_rdata = b64.rdata;
      end else begin
        s_stb = b32.cpu_stb_o; s_busy = b32.busy; s_done = b32.done; s_err = b32.err;
        s_memw = b32.mem_w; s_sel = {4'b0, b32.sel_o}; s_addr = b32.Addr_out;
        s_dout = {32'b0, b32.data_out}; s_rdata = {32'b0, b32.rdata};
      end
      if (s_stb) begin
        if (o_stb_n == 0) begin
          o_sel = s_sel; o_addr = s_addr; o_dout = s_dout; o_memw = s_memw;
        end else if ({s_sel, s_addr, s_dout, s_memw} !== {o_sel, o_addr, o_dout, o_memw}) begin
          o_stable = 1'b0;
        end
        o_stb_n++;
      end
      if (!s_busy) o_busy_ok = 1'b0;
      if (s_done) begin
        got = 1'b1; o_done_cyc = cyc; o_err = s_err; o_rdata = s_rdata;
      end
      if (s.d64) b64.MIO_ready = s_stb && (o_stb_n > s.waits);
      else       b32.MIO_ready = s_stb && (o_stb_n > s.waits);
      @(posedge clk); #1;
    end
    b32.MIO_ready = 1'b0;
    b64.MIO_ready = 1'b0;
    if (got) o_done_once = s.d64 ? !(b64.done || b64.busy) : !(b32.done || b32.busy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({b32.cpu_stb_o, b32.mem_w, b32.busy, b32.done, b32.err, b32.sel_o, b32.Addr_out, b32.data_out, b32.rdata} !== '0)
      $display("FAIL reset32 outputs got %h want 0", {b32.cpu_stb_o, b32.mem_w, b32.busy, b32.done, b32.err, b32.sel_o, b32.Addr_out, b32.data_out, b32.rdata});
    else passed++;
    total++;
    if ({b64.cpu_stb_o, b64.mem_w, b64.busy, b64.done, b64.err, b64.sel_o, b64.Addr_out, b64.data_out, b64.rdata} !== '0)
      $display("FAIL reset64 outputs got %h want 0", {b64.cpu_stb_o, b64.mem_w, b64.busy, b64.done, b64.err, b64.sel_o, b64.Addr_out, b64.data_out, b64.rdata});
    else passed++;
    reset = 1'b0;
    last32 = '0;
    last64 = '0;
  endtask

  task automatic test_loads();
    stim_t st[9];
    exp_t  ex[9];
    exp_t  e, g;
    st[0] = '{d64:0, w:0, sz:2'b00, sx:1, a:32'h103, wd:64'h0, di:64'h80FF_0000, waits:2};
    ex[0] = '{err:0, rdata:64'hFFFF_FF80, keep:0, sel:8'h08, addr:32'h100, dout:64'h0, memw:0, stb_n:3, done_cyc:5};
    st[1] = '{d64:0, w:0, sz:2'b01, sx:0, a:32'h202, wd:64'h0, di:64'h8001_7FFF, waits:0};
    ex[1] = '{err:0, rdata:64'h8001, keep:0, sel:8'h0C, addr:32'h200, dout:64'h0, memw:0, stb_n:1, done_cyc:3};
    st[2] = '{d64:0, w:0, sz:2'b01, sx:1, a:32'h202, wd:64'h0, di:64'h8001_7FFF, waits:1};
    ex[2] = '{err:0, rdata:64'hFFFF_8001, keep:0, sel:8'h0C, addr:32'h200, dout:64'h0, memw:0, stb_n:2, done_cyc:4};
    st[3] = '{d64:0, w:0, sz:2'b10, sx:1, a:32'h100, wd:64'h0, di:64'hDEAD_BEEF, waits:0};
    ex[3] = '{err:0, rdata:64'hDEAD_BEEF, keep:0, sel:8'h0F, addr:32'h100, dout:64'h0, memw:0, stb_n:1, done_cyc:3};
    st[4] = '{d64:0, w:0, sz:2'b00, sx:0, a:32'h101, wd:64'h0, di:64'h1234_56F0, waits:0};
    ex[4] = '{err:0, rdata:64'h56, keep:0, sel:8'h02, addr:32'h100, dout:64'h0, memw:0, stb_n:1, done_cyc:3};
    st[5] = '{d64:0, w:0, sz:2'b00, sx:1, a:32'h100, wd:64'h0, di:64'h1234_56F0, waits:0};
    ex[5] = '{err:0, rdata:64'hFFFF_FFF0, keep:0, sel:8'h01, addr:32'h100, dout:64'h0, memw:0, stb_n:1, done_cyc:3};
    st[6] = '{d64:1, w:0, sz:2'b11, sx:0, a:32'h8, wd:64'h0, di:64'h8123_4567_89AB_CDEF, waits:0};
    ex[6] = '{err:0, rdata:64'h8123_4567_89AB_CDEF, keep:0, sel:8'hFF, addr:32'h8, dout:64'h0, memw:0, stb_n:1, done_cyc:3};
    st[7] = '{d64:1, w:0, sz:2'b10, sx:1, a:32'hC, wd:64'h0, di:64'h8765_4321_0000_0000, waits:1};
    ex[7] = '{err:0, rdata:64'hFFFF_FFFF_8765_4321, keep:0, sel:8'hF0, addr:32'h8, dout:64'h0, memw:0, stb_n:2, done_cyc:4};
    st[8] = '{d64:1, w:0, sz:2'b01, sx:0, a:32'h6, wd:64'h0, di:64'hABCD_0000_0000_0000, waits:0};
    ex[8] = '{err:0, rdata:64'hABCD, keep:0, sel:8'hC0, addr:32'h0, dout:64'h0, memw:0, stb_n:1, done_cyc:3};
    for (int i = 0; i < 9; i++) begin
      e = ex[i];
      if (e.keep) e.rdata = st[i].d64 ? last64 : last32;
      sb_q.push_back(e);
      run_access(st[i]);
      g = sb_q.pop_front();
      total++;
      if (o_done_cyc !== g.done_cyc) $display("FAIL load[%0d] done_cycle got %0d want %0d", i, o_done_cyc, g.done_cyc);
      else passed++;
      total++;
      if ({o_err, o_rdata} !== {g.err, g.rdata}) $display("FAIL load[%0d] err/rdata got %b/%h want %b/%h", i, o_err, o_rdata, g.err, g.rdata);
      else passed++;
      total++;
      if ({o_stb_n, o_busy_ok, o_done_once, o_stable} !== {g.stb_n, 3'b111}) $display("FAIL load[%0d] stb_cycles/busy/done_once/stable got %0d/%b%b%b want %0d/111", i, o_stb_n, o_busy_ok, o_done_once, o_stable, g.stb_n);
      else passed++;
      if (g.stb_n > 0) begin
        total++;
        if ({o_sel, o_addr, o_dout, o_memw} !== {g.sel, g.addr, g.dout, g.memw}) $display("FAIL load[%0d] bus sel/addr/dout/memw got %h/%h/%h/%b want %h/%h/%h/%b", i, o_sel, o_addr, o_dout, o_memw, g.sel, g.addr, g.dout, g.memw);
        else passed++;
      end
      if (!g.err && !st[i].w) begin
        if (st[i].d64) last64 = g.rdata; else last32 = g.rdata;
      end
    end
  endtask

  task automatic test_stores();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e, g;
    st[0] = '{d64:0, w:1, sz:2'b01, sx:0, a:32'h202, wd:64'h1234, di:64'h0, waits:3};
    ex[0] = '{err:0, rdata:64'h0, keep:1, sel:8'h0C, addr:32'h200, dout:64'h1234_0000, memw:1, stb_n:4, done_cyc:6};
    st[1] = '{d64:0, w:1, sz:2'b00, sx:0, a:32'h3, wd:64'hAB, di:64'h0, waits:0};
    ex[1] = '{err:0, rdata:64'h0, keep:1, sel:8'h08, addr:32'h0, dout:64'hAB00_0000, memw:1, stb_n:1, done_cyc:3};
    st[2] = '{d64:0, w:1, sz:2'b10, sx:0, a:32'h10, wd:64'hCAFE_F00D, di:64'h0, waits:0};
    ex[2] = '{err:0, rdata:64'h0, keep:1, sel:8'h0F, addr:32'h10, dout:64'hCAFE_F00D, memw:1, stb_n:1, done_cyc:3};
    st[3] = '{d64:1, w:1, sz:2'b10, sx:0, a:32'h4, wd:64'h1122_3344, di:64'h0, waits:1};
    ex[3] = '{err:0, rdata:64'h0, keep:1, sel:8'hF0, addr:32'h0, dout:64'h1122_3344_0000_0000, memw:1, stb_n:2, done_cyc:4};
    for (int i = 0; i < 4; i++) begin
      e = ex[i];
      if (e.keep) e.rdata = st[i].d64 ? last64 : last32;
      sb_q.push_back(e);
      run_access(st[i]);
      g = sb_q.pop_front();
      total++;
      if (o_done_cyc !== g.done_cyc) $display("FAIL store[%0d] done_cycle got %0d want %0d", i, o_done_cyc, g.done_cyc);
      else passed++;
      total++;
      if ({o_err, o_rdata} !== {g.err, g.rdata}) $display("FAIL store[%0d] err/rdata got %b/%h want %b/%h", i, o_err, o_rdata, g.err, g.rdata);
      else passed++;
      total++;
      if ({o_stb_n, o_busy_ok, o_done_once, o_stable} !== {g.stb_n, 3'b111}) $display("FAIL store[%0d] stb_cycles/busy/done_once/stable got %0d/%b%b%b want %0d/111", i, o_stb_n, o_busy_ok, o_done_once, o_stable, g.stb_n);
      else passed++;
      total++;
      if ({o_sel, o_addr, o_dout, o_memw} !== {g.sel, g.addr, g.dout, g.memw}) $display("FAIL store[%0d] bus sel/addr/dout/memw got %h/%h/%h/%b want %h/%h/%h/%b", i, o_sel, o_addr, o_dout, o_memw, g.sel, g.addr, g.dout, g.memw);
      else passed++;
    end
  endtask

  task automatic test_errors();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  e, g;
    st[0] = '{d64:0, w:0, sz:2'b10, sx:0, a:32'h101, wd:64'h0, di:64'hFFFF_FFFF, waits:0};
    ex[0] = '{err:1, rdata:64'h0, keep:1, sel:8'h0, addr:32'h0, dout:64'h0, memw:0, stb_n:0, done_cyc:2};
    st[1] = '{d64:0, w:1, sz:2'b01, sx:0, a:32'h1, wd:64'h5555, di:64'h0, waits:0};
    ex[1] = '{err:1, rdata:64'h0, keep:1, sel:8'h0, addr:32'h0, dout:64'h0, memw:0, stb_n:0, done_cyc:2};
    st[2] = '{d64:0, w:0, sz:2'b11, sx:0, a:32'h0, wd:64'h0, di:64'h1, waits:0};
    ex[2] = '{err:1, rdata:64'h0, keep:1, sel:8'h0, addr:32'h0, dout:64'h0, memw:0, stb_n:0, done_cyc:2};
    st[3] = '{d64:1, w:0, sz:2'b11, sx:0, a:32'h4, wd:64'h0, di:64'h1, waits:0};
    ex[3] = '{err:1, rdata:64'h0, keep:1, sel:8'h0, addr:32'h0, dout:64'h0, memw:0, stb_n:0, done_cyc:2};
    st[4] = '{d64:0, w:0, sz:2'b10, sx:0, a:32'h40, wd:64'h0, di:64'h55, waits:100};
    ex[4] = '{err:1, rdata:64'h0, keep:1, sel:8'h0F, addr:32'h40, dout:64'h0, memw:0, stb_n:4, done_cyc:6};
    st[5] = '{d64:0, w:0, sz:2'b10, sx:0, a:32'h2, wd:64'h0, di:64'h7, waits:0};
    ex[5] = '{err:1, rdata:64'h0, keep:1, sel:8'h0, addr:32'h0, dout:64'h0, memw:0, stb_n:0, done_cyc:2};
    for (int i = 0; i < 6; i++) begin
      e = ex[i];
      if (e.keep) e.rdata = st[i].d64 ? last64 : last32;
      sb_q.push_back(e);
      run_access(st[i]);
      g = sb_q.pop_front();
      total++;
      if (o_done_cyc !== g.done_cyc) $display("FAIL error[%0d] done_cycle got %0d want %0d", i, o_done_cyc, g.done_cyc);
      else passed++;
      total++;
      if ({o_err, o_rdata} !== {g.err, g.rdata}) $display("FAIL error[%0d] err/rdata got %b/%h want %b/%h", i, o_err, o_rdata, g.err, g.rdata);
      else passed++;
      total++;
      if ({o_stb_n, o_busy_ok, o_done_once, o_stable} !== {g.stb_n, 3'b111}) $display("FAIL error[%0d] stb_cycles/busy/done_once/stable got %0d/%b%b%b want %0d/111", i, o_stb_n, o_busy_ok, o_done_once, o_stable, g.stb_n);
      else passed++;
      if (g.stb_n > 0) begin
        total++;
        if ({o_sel, o_addr, o_dout, o_memw} !== {g.sel, g.addr, g.dout, g.memw}) $display("FAIL error[%0d] bus sel/addr/dout/memw got %h/%h/%h/%b want %h/%h/%h/%b", i, o_sel, o_addr, o_dout, o_memw, g.sel, g.addr, g.dout, g.memw);
        else passed++;
      end
    end
  endtask

  // req held high throughout: the second access starts only after the done cycle.
  task automatic test_back_to_back();
    logic [7:0] stb_seq, done_seq;
    exp_t       e, g;
    e = '{err:0, rdata:64'h0BAD_BEEF, keep:0, sel:8'h0F, addr:32'h20, dout:64'h0, memw:0, stb_n:1, done_cyc:3};
    sb_q.push_back(e);
    sb_q.push_back(e);
    stb_seq = '0;
    done_seq = '0;
    b32.we = 1'b0; b32.size = 2'b10; b32.sign_ext = 1'b0; b32.addr = 32'h20;
    b32.data_in = 32'h0BAD_BEEF; b32.req = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      stb_seq[cyc-1]  = b32.cpu_stb_o;
      done_seq[cyc-1] = b32.done;
      if (b32.done && sb_q.size() > 0) begin
        g = sb_q.pop_front();
        total++;
        if ({b32.err, b32.rdata} !== {g.err, g.rdata[31:0]}) $display("FAIL b2b rdata got %b/%h want %b/%h", b32.err, b32.rdata, g.err, g.rdata[31:0]);
        else passed++;
      end
      b32.MIO_ready = b32.cpu_stb_o;
      if (cyc == 5) b32.req = 1'b0;
      @(posedge clk); #1;
    end
    b32.MIO_ready = 1'b0;
    b32.req = 1'b0;
    total++;
    if (stb_seq !== 8'b0001_0001) $display("FAIL b2b strobe_pattern got %b want %b", stb_seq, 8'b0001_0001);
    else passed++;
    total++;
    if (done_seq !== 8'b0100_0100) $display("FAIL b2b done_pattern got %b want %b", done_seq, 8'b0100_0100);
    else passed++;
    total++;
    if (sb_q.size() !== 0) $display("FAIL b2b pending_results got %0d want 0", sb_q.size());
    else passed++;
    last32 = 64'h0BAD_BEEF;
  endtask

  task automatic test_reset_mid_access();
    logic saw_done, saw_stb;
    b32.we = 1'b0; b32.size = 2'b10; b32.sign_ext = 1'b0; b32.addr = 32'h30;
    b32.data_in = 32'h1357_9BDF; b32.req = 1'b1;
    @(posedge clk); #1;
    b32.req = 1'b0;
    total++;
    if (b32.cpu_stb_o !== 1'b1) $display("FAIL midreset strobe_before got %b want 1", b32.cpu_stb_o);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b1; b32.req = 1'b1; b32.MIO_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; b32.req = 1'b0;
    total++;
    if ({b32.cpu_stb_o, b32.mem_w, b32.busy, b32.done, b32.err, b32.sel_o, b32.Addr_out, b32.data_out, b32.rdata} !== '0)
      $display("FAIL midreset outputs got %h want 0", {b32.cpu_stb_o, b32.mem_w, b32.busy, b32.done, b32.err, b32.sel_o, b32.Addr_out, b32.data_out, b32.rdata});
    else passed++;
    total++;
    if (b64.rdata !== 64'h0) $display("FAIL midreset rdata64 got %h want 0", b64.rdata);
    else passed++;
    saw_done = 1'b0;
    saw_stb = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      saw_done |= b32.done;
      saw_stb  |= b32.cpu_stb_o | b32.busy;
    end
    b32.MIO_ready = 1'b0;
    total++;
    if ({saw_done, saw_stb} !== 2'b00) $display("FAIL midreset idle_ready done/activity got %b want 00", {saw_done, saw_stb});
    else passed++;
    last32 = '0;
    last64 = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1;
    b32.req = 0; b32.we = 0; b32.size = 0; b32.sign_ext = 0; b32.addr = 0; b32.wdata = 0;
    b32.data_in = 0; b32.MIO_ready = 0;
    b64.req = 0; b64.we = 0; b64.size = 0; b64.sign_ext = 0; b64.addr = 0; b64.wdata = 0;
    b64.data_in = 0; b64.MIO_ready = 0;
    @(posedge clk); #1;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    test_loads();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
